// File: rtl/lsu_byte_seq_if.sv
// Byte-wide data memory bus between lsu_byte_seq and its memory.
// MRdData is registered: it returns the byte addressed one cycle earlier.
interface lsu_byte_seq_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] MAd;
  logic [7:0]        MWrData;
  logic              MemWr;
  logic [7:0]        MRdData;

  modport master (
    output MAd,
    output MWrData,
    output MemWr,
    input  MRdData
  );

  modport slave (
    input  MAd,
    input  MWrData,
    input  MemWr,
    output MRdData
  );
endinterface

// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store sequencer, little-endian, 32-bit extended loads.
// Define LSU_ALIGN_CHECK_EN to reject misaligned half/word requests.
module lsu_byte_seq #(
  parameter int ADDR_W = 6
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Wr,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] RData,
  output logic        Misalign,
  lsu_byte_seq_if.master mem
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    LAST,
    DONE
  } state_t;

  state_t            state;
  logic [1:0]        cnt;
  logic [1:0]        last;
  logic              wr_q;
  logic              sgn_q;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdat;
  logic [31:0]       buf_q;

  logic [1:0]  nlast;
  logic [1:0]  prv;
  logic        bad;
  logic [31:0] full;
  logic [31:0] res;

  wire unused_ok = &{1'b0, Addr[31:ADDR_W]};

  always_comb begin
    nlast = 2'd3;
    unique case (1'b1)
      Size == 2'b00: nlast = 2'd0;
      Size == 2'b01: nlast = 2'd1;
      default:       nlast = 2'd3;
    endcase
  end

`ifdef LSU_ALIGN_CHECK_EN
  assign bad = (Size == 2'b01 && Addr[0])
            || (Size[1] && Addr[1:0] != 2'b00);
`else
  assign bad = 1'b0;
`endif

  assign prv = cnt - 2'd1;

  // Top byte arrives on MRdData in the same cycle the result is latched.
  always_comb begin
    full = buf_q;
    full[{last, 3'b000} +: 8] = mem.MRdData;
    res = full;
    unique case (last)
      2'd0:    res = {{24{sgn_q & full[7]}}, full[7:0]};
      2'd1:    res = {{16{sgn_q & full[15]}}, full[15:0]};
      default: res = full;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      last     <= 2'd0;
      wr_q     <= 1'b0;
      sgn_q    <= 1'b0;
      base     <= '0;
      wdat     <= 32'd0;
      buf_q    <= 32'd0;
      RData    <= 32'd0;
      Misalign <= 1'b0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state)
        IDLE: if (Req) begin
          wr_q     <= Wr;
          sgn_q    <= Signed;
          last     <= nlast;
          base     <= Addr[ADDR_W-1:0];
          wdat     <= WData;
          cnt      <= 2'd0;
          buf_q    <= 32'd0;
          Misalign <= bad;
          Busy     <= 1'b1;
          if (bad) begin
            state <= DONE;
            Done  <= 1'b1;
          end else begin
            state <= XFER;
          end
        end
        XFER: begin
          cnt <= cnt + 2'd1;
          if (!wr_q && cnt != 2'd0)
            buf_q[{prv, 3'b000} +: 8] <= mem.MRdData;
          if (cnt == last) begin
            if (wr_q) begin
              state <= DONE;
              Done  <= 1'b1;
            end else begin
              state <= LAST;
            end
          end
        end
        LAST: begin
          RData <= res;
          state <= DONE;
          Done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.MemWr   = (state == XFER) && wr_q;
  assign mem.MAd     = (state == XFER) ? base + ADDR_W'(cnt) : '0;
  assign mem.MWrData = (state == XFER) ? wdat[{cnt, 3'b000} +: 8]
                                       : 8'h00;

endmodule
